// File: rtl/spi_cmd_responder_pkg.sv
// Shared command codes, response words and state encodings for the SPI responder.
package spi_cmd_responder_pkg;

  // Command field, rx[15:11]
  localparam logic [4:0] CmdRdReg     = 5'b00110;
  localparam logic [4:0] CmdWrReg     = 5'b11000;
  localparam logic [4:0] CmdStartConv = 5'b10100;
  localparam logic [4:0] CmdReadData  = 5'b01010;
  localparam logic [4:0] CmdReset     = 5'b00001;
  // READSINGLE only decodes rx[15:12]; rx[11] is part of the channel index
  localparam logic [3:0] CmdReadSingle = 4'b1110;

  // Response words
  localparam logic [15:0] RespAck    = 16'h3355;
  localparam logic [15:0] RespErr    = 16'hABCD;
  localparam logic [4:0]  RespRegTag = 5'b11000;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StStream
  } state_e;

  // Which registered source feeds the pending response one cycle after decode
  typedef enum logic [1:0] {
    CapNone,
    CapReg,
    CapAdc
  } capture_e;

endpackage

// File: rtl/spi_cmd_responder_sync_edge.sv
// Input synchroniser with rise/fall detection on the synchronised level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(din);
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_cmd_responder.sv
// SPI responder: deserialises 16-bit host words, decodes commands into register-file
// and ADC-buffer accesses, and returns each word's response during the following word.
module spi_cmd_responder import spi_cmd_responder_pkg::*; #(
  parameter int unsigned NREGISTERS  = 8,
  parameter int unsigned NUMCHANNELS = 16,
  parameter int unsigned WORDBITS    = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           CLK,
  input  logic                           NRST,
  input  logic                           SCK,
  input  logic                           CS,
  input  logic                           PICO,
  output logic                           POCI,
  output logic                           reg_wr_en,
  output logic [$clog2(NREGISTERS)-1:0]  reg_addr,
  output logic [7:0]                     reg_wdata,
  input  logic [7:0]                     reg_rdata,
  output logic                           start_conv,
  output logic                           soft_rst,
  input  logic                           data_rdy,
  output logic [$clog2(NUMCHANNELS)-1:0] adc_idx,
  input  logic [WORDBITS-1:0]            adc_data
);

  localparam int unsigned AW = $clog2(NREGISTERS);
  localparam int unsigned IW = $clog2(NUMCHANNELS);
  localparam int unsigned CW = $clog2(WORDBITS);
  localparam logic [IW-1:0] LastIdx = IW'(NUMCHANNELS - 1);
  localparam logic [CW-1:0] LastBit = CW'(WORDBITS - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic pico_lvl, pico_rise, pico_fall;
  logic unused_edges;

  state_e              state_q;
  capture_e            cap_q;
  logic [WORDBITS-1:0] rx_q;
  logic [WORDBITS-1:0] tx_q;
  logic [WORDBITS-1:0] pending_q;
  logic [WORDBITS-1:0] pending_d;
  logic [CW-1:0]       cnt_q;
  logic                word_q;  // a complete word sits in rx_q, decode this cycle
  logic                load_q;  // next SCK fall loads tx from the pending response

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sck (
    .clk   (CLK),
    .rst_n (NRST),
    .din   (SCK),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (CLK),
    .rst_n (NRST),
    .din   (CS),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_pico (
    .clk   (CLK),
    .rst_n (NRST),
    .din   (PICO),
    .level (pico_lvl),
    .rise  (pico_rise),
    .fall  (pico_fall)
  );

  assign unused_edges = ^{sck_lvl, pico_rise, pico_fall};

  // Pending response after any capture of combinational read data this cycle; tx loads
  // from here so a capture coinciding with an SCK fall is not missed.
  always_comb begin
    pending_d = pending_q;
    case (cap_q)
      CapReg:  pending_d = WORDBITS'({RespRegTag, reg_addr, reg_rdata});
      CapAdc:  pending_d = adc_data;
      default: pending_d = pending_q;
    endcase
  end

  // Shift engine, command decode and state machine
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q    <= StIdle;
      cap_q      <= CapNone;
      rx_q       <= '0;
      tx_q       <= '0;
      pending_q  <= '0;
      cnt_q      <= '0;
      word_q     <= 1'b0;
      load_q     <= 1'b0;
      reg_wr_en  <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      start_conv <= 1'b0;
      soft_rst   <= 1'b0;
      adc_idx    <= '0;
    end else begin
      reg_wr_en  <= 1'b0;
      start_conv <= 1'b0;
      soft_rst   <= 1'b0;
      word_q     <= 1'b0;
      cap_q      <= CapNone;
      pending_q  <= pending_d;

      // Bit-level shifting, only while CS is low
      if (cs_fall) begin
        tx_q   <= pending_d;
        cnt_q  <= '0;
        load_q <= 1'b1;
      end else if (cs_rise) begin
        cnt_q  <= '0;
        load_q <= 1'b0;
      end else if (!cs_lvl) begin
        if (sck_rise) begin
          rx_q <= {rx_q[WORDBITS-2:0], pico_lvl};
          if (cnt_q == LastBit) begin
            cnt_q  <= '0;
            word_q <= 1'b1;
            load_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        if (sck_fall) begin
          if (load_q) begin
            tx_q   <= pending_d;
            load_q <= 1'b0;
          end else begin
            tx_q <= tx_q << 1;
          end
        end
      end

      // Word decode; overrides of pending_q here win over the default above
      if (word_q) begin
        if (state_q == StStream) begin
          if (adc_idx == LastIdx) begin
            pending_q <= WORDBITS'(RespErr);
          end else begin
            adc_idx <= adc_idx + 1'b1;
            cap_q   <= CapAdc;
          end
        end else if (rx_q[WORDBITS-1 -: 4] == CmdReadSingle) begin
          adc_idx <= rx_q[8 +: IW];
          cap_q   <= CapAdc;
        end else begin
          case (rx_q[WORDBITS-1 -: 5])
            CmdWrReg: begin
              reg_addr  <= rx_q[8 +: AW];
              reg_wdata <= rx_q[7:0];
              reg_wr_en <= 1'b1;
              pending_q <= WORDBITS'(RespAck);
            end
            CmdRdReg: begin
              reg_addr <= rx_q[8 +: AW];
              cap_q    <= CapReg;
            end
            CmdStartConv: begin
              start_conv <= 1'b1;
              pending_q  <= WORDBITS'(RespAck);
            end
            CmdReadData: begin
              if (data_rdy && state_q == StCmd) begin
                state_q <= StStream;
                adc_idx <= '0;
                cap_q   <= CapAdc;
              end else begin
                pending_q <= WORDBITS'(RespErr);
              end
            end
            CmdReset: begin
              soft_rst  <= 1'b1;
              pending_q <= WORDBITS'(RespAck);
            end
            default: pending_q <= WORDBITS'(RespErr);
          endcase
        end
      end

      // Frame boundaries last so a same-cycle CS rise still ends in IDLE
      if (cs_fall) begin
        state_q <= StCmd;
      end else if (cs_rise) begin
        state_q <= StIdle;
      end
    end
  end

  assign POCI = ~cs_lvl & tx_q[WORDBITS-1];

endmodule

// File: tb/tb_spi_cmd_responder.sv
// Directed bench for spi_cmd_responder with a response scoreboard.
module tb_spi_cmd_responder;

  logic        CLK = 1'b0;
  logic        NRST;
  logic        SCK;
  logic        CS;
  logic        PICO;
  logic        POCI;
  logic        reg_wr_en;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        start_conv;
  logic        soft_rst;
  logic        data_rdy;
  logic [3:0]  adc_idx;
  logic [15:0] adc_data;

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;
  int conv_cycles = 0;
  int rst_cycles = 0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [15:0] exp_q[$];
  logic [15:0] got;

  spi_cmd_responder dut (
    .CLK        (CLK),
    .NRST       (NRST),
    .SCK        (SCK),
    .CS         (CS),
    .PICO       (PICO),
    .POCI       (POCI),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .start_conv (start_conv),
    .soft_rst   (soft_rst),
    .data_rdy   (data_rdy),
    .adc_idx    (adc_idx),
    .adc_data   (adc_data)
  );

  always #5 CLK = ~CLK;

  // Result buffer model: slot i holds 0x1000 + i
  assign adc_data = 16'h1000 + {12'h000, adc_idx};

  // Strobe monitor: counts high cycles so a stretched pulse is visible
  always @(posedge CLK) begin
    if (reg_wr_en) begin
      wr_cycles++;
      wr_addr = reg_addr;
      wr_data = reg_wdata;
    end
    if (start_conv) conv_cycles++;
    if (soft_rst) rst_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer_bits(input logic [15:0] w, input int nbits, output logic [15:0] q);
    q = '0;
    for (int i = 0; i < nbits; i++) begin
      SCK  = 1'b0;
      PICO = w[15-i];
      #50;
      SCK = 1'b1;
      q   = {q[14:0], POCI};
      #50;
    end
  endtask

  // Pops this word's expected response, pushes the response this word should cause
  task automatic send_word(input string tag, input logic [15:0] w, input logic [15:0] nxt);
    logic [15:0] exp;
    logic [15:0] q;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    exp_q.push_back(nxt);
    xfer_bits(w, 16, q);
    check(tag, {16'h0, q}, {16'h0, exp});
  endtask

  task automatic cs_low();
    CS = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    #100;
    CS = 1'b1;
    #200;
  endtask

  initial begin
    NRST      = 1'b0;
    SCK       = 1'b1;
    CS        = 1'b1;
    PICO      = 1'b0;
    data_rdy  = 1'b0;
    reg_rdata = 8'hFF;
    #52;
    check("rst_poci", {31'h0, POCI}, 32'h0);
    check("rst_wr_en", {31'h0, reg_wr_en}, 32'h0);
    check("rst_addr", {29'h0, reg_addr}, 32'h0);
    check("rst_wdata", {24'h0, reg_wdata}, 32'h0);
    check("rst_adc_idx", {28'h0, adc_idx}, 32'h0);
    check("rst_conv", {31'h0, start_conv}, 32'h0);
    check("rst_soft", {31'h0, soft_rst}, 32'h0);
    NRST = 1'b1;
    #100;
    exp_q.push_back(16'h0000);

    // WRREG reg 5 = 0xA4, then the ack
    cs_low();
    send_word("wrreg", 16'hC5A4, 16'h3355);
    send_word("wrreg_ack", 16'h0000, 16'hABCD);
    cs_high();
    check("wr_cycles", wr_cycles, 1);
    check("wr_addr", {29'h0, wr_addr}, 32'h5);
    check("wr_data", {24'h0, wr_data}, 32'hA4);

    // RDREG reg 3 with rdata 0xFF
    cs_low();
    send_word("rdreg", 16'h3300, 16'hC3FF);
    send_word("rdreg_data", 16'h0000, 16'hABCD);
    cs_high();

    // STARTCONV, READDATA without data ready, RESET
    cs_low();
    send_word("startconv", 16'hA000, 16'h3355);
    send_word("startconv_ack", 16'h5000, 16'hABCD);
    send_word("readdata_nrdy", 16'h0800, 16'h3355);
    send_word("reset_ack", 16'h0000, 16'hABCD);
    cs_high();
    check("conv_cycles", conv_cycles, 1);
    check("rst_cycles", rst_cycles, 1);

    // READSINGLE channel 7, answered in a separate frame
    cs_low();
    send_word("readsingle", 16'hE700, 16'h1007);
    cs_high();
    cs_low();
    send_word("readsingle_data", 16'h0000, 16'hABCD);
    cs_high();

    // Streaming 17-word frame plus one word past the last channel
    data_rdy = 1'b1;
    cs_low();
    send_word("readdata", 16'h5000, 16'h1000);
    for (int k = 2; k <= 18; k++) begin
      send_word($sformatf("stream%0d", k), (k == 5) ? 16'hC1A4 : 16'h0000,
                (k <= 16) ? 16'h1000 + 16'(k - 1) : 16'hABCD);
    end
    cs_high();
    data_rdy = 1'b0;
    check("stream_no_wr", wr_cycles, 1);

    // SCK toggling with CS high
    for (int i = 0; i < 16; i++) begin
      SCK  = 1'b0;
      PICO = 1'($urandom_range(1, 0));
      #50;
      SCK = 1'b1;
      check("poci_cs_high", {31'h0, POCI}, 32'h0);
      #50;
    end

    // WRREG aborted after 9 bits
    cs_low();
    xfer_bits(16'hC5A4, 9, got);
    cs_high();
    check("abort_no_wr", wr_cycles, 1);

    // Pending response survives the abort; stream has ended so RESET decodes
    cs_low();
    send_word("after_abort", 16'h0800, 16'h3355);
    send_word("reset2_ack", 16'h0000, 16'hABCD);
    cs_high();
    check("rst_cycles2", rst_cycles, 2);

    // Reset in the middle of a stream
    data_rdy = 1'b1;
    cs_low();
    send_word("readdata2", 16'h5000, 16'h1000);
    send_word("stream2_a", 16'h0000, 16'h1001);
    send_word("stream2_b", 16'h0000, 16'h1002);
    #100;
    check("stream2_idx", {28'h0, adc_idx}, 32'h2);
    xfer_bits(16'h0000, 5, got);
    NRST = 1'b0;
    #1;
    check("mrst_poci", {31'h0, POCI}, 32'h0);
    check("mrst_adc_idx", {28'h0, adc_idx}, 32'h0);
    check("mrst_addr", {29'h0, reg_addr}, 32'h0);
    check("mrst_wdata", {24'h0, reg_wdata}, 32'h0);
    check("mrst_strobes", {29'h0, reg_wr_en, start_conv, soft_rst}, 32'h0);
    SCK = 1'b1;
    CS  = 1'b1;
    #100;
    NRST = 1'b1;
    data_rdy = 1'b0;
    #100;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    cs_low();
    send_word("post_reset", 16'h0000, 16'hABCD);
    cs_high();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_responder.md
Name: spi_cmd_responder

Overview:
- On-chip SPI peripheral (responder) for the controller-side host protocol: 16-bit words, MSB first, CS active-low.
- Deserialises host words, decodes the 5-bit command field and drives register-file write/read ports and the conversion-start strobe.
- Streams ADC results from the result buffer, and serialises each response word on POCI during the host's following word.
- Sits between the chip pads (SCK/PICO/CS/POCI) and the config register file / sample-capture buffer, all in the CLK domain.

Parameters:
- NREGISTERS, 8, number of config registers (address width 3).
- NUMCHANNELS, 16, ADC result slots (index width 4).
- WORDBITS, 16, SPI word length.
- SYNC_STAGES, 2, synchroniser depth on SCK/CS/PICO.

Ports:
- CLK  in  1  system clock.
- NRST  in  1  asynchronous active-low reset.
- SCK  in  1  SPI clock, idles high, ≤ CLK/4.
- CS  in  1  chip select, active low.
- PICO  in  1  host-to-chip data, sampled on SCK rise.
- POCI  out  1  chip-to-host data, changes on SCK fall.
- reg_wr_en  out  1  one-cycle register write strobe.
- reg_addr  out  3  register address (read and write).
- reg_wdata  out  8  write data.
- reg_rdata  in  8  combinational read data for reg_addr.
- start_conv  out  1  one-cycle conversion-start pulse.
- soft_rst  out  1  one-cycle subsystem reset pulse.
- data_rdy  in  1  result buffer holds a complete frame.
- adc_idx  out  4  result buffer read index.
- adc_data  in  16  result word at adc_idx (0x8000 for disabled channels, supplied by buffer).

Behaviour:
- Reset (NRST low, any time including mid-frame): POCI=0, reg_wr_en=0, start_conv=0, soft_rst=0, reg_addr=0, reg_wdata=0, adc_idx=0, pending response=0x0000, state IDLE, bit counter 0.
- SCK, CS and PICO each pass through SYNC_STAGES flops; edge detection operates on the synchronised signals.
- CS fall: tx shift register <= pending response; bit counter <= 0; POCI = tx[15].
- Synced SCK rise: rx <= {rx[14:0], PICO}; counter++. On the 16th rise the word is complete: decode in the next CLK cycle; counter <= 0.
- Synced SCK fall:
  - First fall after a completed word: tx <= new pending response.
  - Otherwise: tx <= tx << 1.
  - Decode always finishes before this edge because SCK ≤ CLK/4.
- POCI = tx[15] while CS low, else 0.
- CS rise mid-word: discard partial rx, counter <= 0, pending response unchanged, stream terminated.
- Response latency: the response to word N is shifted out during word N+1. Word N+1 may lie in the same or a later frame; the pending response persists across CS high.
- Decode on rx[15:11]:
  - 11000 WRREG: reg_addr=rx[10:8], reg_wdata=rx[7:0], reg_wr_en pulse 1 cycle. Pending = 0x3355.
  - 00110 RDREG: reg_addr=rx[10:8]. Pending = {11000, addr, reg_rdata}, captured the cycle after reg_addr updates.
  - 10100 STARTCONV: start_conv pulse. Pending = 0x3355.
  - 01010 READDATA:
    - data_rdy=0: pending = 0xABCD.
    - data_rdy=1: enter STREAM, adc_idx=0, pending = adc_data[0].
  - 1110x READDATASINGLE: adc_idx=rx[11:8]. Pending = adc_data, regardless of data_rdy.
  - 00001 RESET: soft_rst pulse. Pending = 0x3355. The block itself is not reset.
  - any other code: pending = 0xABCD.
- States: IDLE (CS high) -> CMD on CS fall. CMD -> STREAM on a valid READDATA. STREAM -> IDLE on CS rise. CMD -> IDLE on CS rise.
- STREAM:
  - Each completed word is ignored as a command; adc_idx++ and pending = adc_data[adc_idx].
  - After index NUMCHANNELS-1 the index saturates and pending = 0xABCD for further words.
- SCK toggling with CS high: no shifting, no decode, POCI stays 0.
- Word decode and CS rise in the same cycle: the decode completes first, then state goes to IDLE.

Decomposition:
- Shared package holds the command codes (RDREG 00110, WRREG 11000, STARTCONV 10100, READDATA 01010, READSINGLE 1110, RESET 00001), the response constants (ACK 0x3355, ERR 0xABCD, REGDATA tag 11000) and the state enum.
- One natural sub-module: spi_sync_edge, which covers the synchroniser plus rise/fall detect and is instantiated once per input.

Test Plan:
- WRREG 0xC5A4 (reg 5 = 0xA4) -> reg_wr_en one cycle, addr 5, wdata 0xA4. The next word returns 0x3355.
- RDREG 0x3300 with reg_rdata=0xFF (two-word frame) -> second word reads 0xC3FF.
- READDATA with data_rdy=0 -> next word 0xABCD. With data_rdy=1 and 17-word frame, buffer i=0x1000+i -> words 2..17 read 0x1000..0x100F; an 18th word reads 0xABCD.
- READSINGLE 0xE700 then separate frame -> returns adc_data[7]. Code 0x0000 -> 0xABCD.
- 16 SCK cycles with CS high, then CS pulled high at bit 9 of a WRREG -> no reg_wr_en, no POCI activity; the pending response is unchanged in the next frame.
- NRST asserted mid-STREAM -> all outputs at reset values within one cycle. The next frame first word returns 0x0000.
